// File: rtl/if_id_reg_pkg.sv
// Shared definitions for the IF/ID pipeline buffer: widths, NOP encoding,
// state encodings, control enable levels and the buffered entry payload.
package if_id_reg_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [DATA_W-1:0] NOP_INST = 16'h0800;

  // Enable levels of the control inputs
  localparam logic CLEAR_LVL = 1'b1;
  localparam logic PAUSE_LVL = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  // Value held by an unoccupied slot
  function automatic entry_t empty_entry();
    entry_t e;
    e.pc   = '0;
    e.inst = NOP_INST;
    return e;
  endfunction

endpackage : if_id_reg_pkg

// File: rtl/if_id_perf_cnt.sv
// Saturating flush/stall event counters for the IF/ID buffer.
module if_id_perf_cnt
  import if_id_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_ev,
  input  logic             stall_ev,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush_ev && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (stall_ev && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule : if_id_perf_cnt

// File: rtl/if_id_reg.sv
// IF/ID pipeline register built as a 2-entry in-order buffer (head + skid).
// Optional flush/stall counters are included when IF_ID_PERF_CNT_EN is defined.
module if_id_reg
  import if_id_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              pause,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  state_t state, state_nxt;
  entry_t head, head_nxt;
  entry_t skid, skid_nxt;
  entry_t in_entry;
  logic   flush, push, pop;

  assign flush    = (clear == CLEAR_LVL);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && (pause != PAUSE_LVL) && !flush;
  assign in_entry = '{pc: if_pc, inst: if_inst};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= empty_entry();
      skid <= empty_entry();
    end else begin
      head <= head_nxt;
      skid <= skid_nxt;
    end
  end

  // Next state and entry update; flush wins over push and pop
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (flush) begin
      state_nxt = ST_EMPTY;
      head_nxt  = empty_entry();
      skid_nxt  = empty_entry();
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state_nxt = ST_ONE;
            head_nxt  = in_entry;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_nxt = in_entry;
          end else if (push) begin
            state_nxt = ST_TWO;
            skid_nxt  = in_entry;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
            head_nxt  = empty_entry();
          end
        end
        ST_TWO: begin
          // Full: no push possible, pop shifts skid into head
          if (pop) begin
            state_nxt = ST_ONE;
            head_nxt  = skid;
            skid_nxt  = empty_entry();
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          head_nxt  = empty_entry();
          skid_nxt  = empty_entry();
        end
      endcase
    end
  end

  // Outputs decoded from state and head entry only
  always_comb begin
    if_ready = 1'b1;
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = NOP_INST;
    if (state != ST_EMPTY) begin
      id_valid = 1'b1;
      id_pc    = head.pc;
      id_inst  = head.inst;
    end
    if (state == ST_TWO) if_ready = 1'b0;
  end

`ifdef IF_ID_PERF_CNT_EN
  logic flush_ev, stall_ev;

  assign flush_ev = flush && (state != ST_EMPTY);
  assign stall_ev = (pause == PAUSE_LVL) && !flush && id_valid;

  if_id_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .flush_ev  (flush_ev),
    .stall_ev  (stall_ev),
    .flush_cnt (flush_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule : if_id_reg

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg (define IF_ID_PERF_CNT_EN to
// also exercise the counters).
module tb_if_id_reg;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        pause;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_inst;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] flush_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_id_reg dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .pause    (pause),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .flush_cnt(flush_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                       input logic p, input logic c);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    pause    = p;
    clear    = c;
  endtask

  task automatic expect_out(input string name, input logic ev, input logic [15:0] epc,
                            input logic [15:0] einst, input logic erdy);
    // Inline comparison block reused for the four visible outputs
    checks++;
    if ({id_valid, id_pc, id_inst, if_ready} !== {ev, epc, einst, erdy}) begin
      errors++;
      $display("FAIL %s: got valid=%b pc=%h inst=%h ready=%b, want valid=%b pc=%h inst=%h ready=%b",
               name, id_valid, id_pc, id_inst, if_ready, ev, epc, einst, erdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_out("reset_values", 1'b0, 16'h0000, 16'h0800, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
    checks++;
    if (flush_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt: got flush=%h stall=%h, want 0/0", flush_cnt, stall_cnt);
    end
`endif
    rst = 1'b1;
    tick();
    expect_out("idle_after_reset", 1'b0, 16'h0000, 16'h0800, 1'b1);
  endtask

  task automatic test_pass_through();
    drive(1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0);
    tick();
    expect_out("pass_first", 1'b1, 16'h0010, 16'h1234, 1'b1);
    drive(1'b1, 16'h0011, 16'h5678, 1'b0, 1'b0);
    tick();
    expect_out("pass_second", 1'b1, 16'h0011, 16'h5678, 1'b1);
    // Garbage on if_* with if_valid low must be ignored
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick();
    expect_out("drain_to_empty", 1'b0, 16'h0000, 16'h0800, 1'b1);
    tick();
    expect_out("ignore_invalid", 1'b0, 16'h0000, 16'h0800, 1'b1);
  endtask

  task automatic test_pause_fill();
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] s0;
    s0 = stall_cnt;
`endif
    drive(1'b1, 16'h0020, 16'hA020, 1'b1, 1'b0);
    tick();
    expect_out("pause_c1", 1'b1, 16'h0020, 16'hA020, 1'b1);
    drive(1'b1, 16'h0021, 16'hA021, 1'b1, 1'b0);
    tick();
    expect_out("pause_c2_full", 1'b1, 16'h0020, 16'hA020, 1'b0);
    drive(1'b1, 16'h0022, 16'hA022, 1'b1, 1'b0);
    tick();
    expect_out("pause_c3_refused", 1'b1, 16'h0020, 16'hA020, 1'b0);
`ifdef IF_ID_PERF_CNT_EN
    checks++;
    if (stall_cnt !== s0 + 16'd2) begin
      errors++;
      $display("FAIL stall_count: got %h want %h", stall_cnt, s0 + 16'd2);
    end
`endif
  endtask

  task automatic test_drain();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_out("drain_skid", 1'b1, 16'h0021, 16'hA021, 1'b1);
    tick();
    expect_out("drain_empty_no_0022", 1'b0, 16'h0000, 16'h0800, 1'b1);
  endtask

  task automatic test_clear();
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] f0;
`endif
    drive(1'b1, 16'h0030, 16'hB030, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0031, 16'hB031, 1'b1, 1'b0);
    tick();
    expect_out("clear_prefill", 1'b1, 16'h0030, 16'hB030, 1'b0);
`ifdef IF_ID_PERF_CNT_EN
    f0 = flush_cnt;
`endif
    drive(1'b1, 16'h0032, 16'hB032, 1'b1, 1'b1);
    tick();
    expect_out("clear_flush", 1'b0, 16'h0000, 16'h0800, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
    checks++;
    if (flush_cnt !== f0 + 16'd1) begin
      errors++;
      $display("FAIL flush_count: got %h want %h", flush_cnt, f0 + 16'd1);
    end
    // Clear while empty is not a flush event
    tick();
    checks++;
    if (flush_cnt !== f0 + 16'd1) begin
      errors++;
      $display("FAIL flush_empty: got %h want %h", flush_cnt, f0 + 16'd1);
    end
`endif
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_out("clear_push_dropped", 1'b0, 16'h0000, 16'h0800, 1'b1);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h0040, 16'hC040, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    expect_out("areset_pre", 1'b1, 16'h0040, 16'hC040, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    expect_out("areset_immediate", 1'b0, 16'h0000, 16'h0800, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
    checks++;
    if (flush_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL areset_cnt: got flush=%h stall=%h, want 0/0", flush_cnt, stall_cnt);
    end
`endif
    #2;
    rst = 1'b1;
    tick();
    expect_out("areset_stays_empty", 1'b0, 16'h0000, 16'h0800, 1'b1);
    drive(1'b1, 16'h0050, 16'hD050, 1'b0, 1'b0);
    tick();
    expect_out("areset_first_push", 1'b1, 16'h0050, 16'hD050, 1'b1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_out("areset_drain", 1'b0, 16'h0000, 16'h0800, 1'b1);
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_stall_sat();
    drive(1'b1, 16'h0060, 16'hE060, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h want ffff", stall_cnt);
    end
    expect_out("stall_hold", 1'b1, 16'h0060, 16'hE060, 1'b1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_pause_fill();
    test_drain();
    test_clear();
    test_async_reset();
`ifdef IF_ID_PERF_CNT_EN
    test_stall_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_if_id_reg

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have the clock first: clk, input, 1, rising-edge clock.
REQ-002 SHALL have the reset second: rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have clear, input, 1, flush request from the jump controller (1 = flush).
REQ-004 SHALL have pause, input, 1, stall request (1 = hold the ID-side output).
REQ-005 SHALL have if_valid, input, 1, the fetch stage presents an instruction.
REQ-006 SHALL have if_pc, input, 16, PC of the fetched instruction.
REQ-007 SHALL have if_inst, input, 16, fetched instruction word.
REQ-008 SHALL have if_ready, output, 1, the buffer accepts if_* this cycle.
REQ-009 SHALL have id_valid, output, 1, id_pc and id_inst are meaningful.
REQ-010 SHALL have id_pc, output, 16, PC passed to decode.
REQ-011 SHALL have id_inst, output, 16, instruction passed to decode (NOP when id_valid=0).

Function
REQ-012 SHALL be a 2-entry in-order buffer (head, skid) with state EMPTY/ONE/TWO.
REQ-013 SHALL accept if_* on a rising edge iff if_valid && if_ready; if_ready = (state != TWO), combinational from state only.
REQ-014 SHALL advance the head (pop) on a rising edge iff id_valid && !pause && !clear.
REQ-015 SHALL apply these transitions: EMPTY+push -> ONE; ONE+push+pop -> ONE; ONE+push -> TWO; ONE+pop -> EMPTY; TWO+pop -> ONE (skid moves to head); other cases hold.
REQ-016 SHALL drive id_valid = (state != EMPTY); id_pc/id_inst from the head entry; id_inst = NOP (0x0800) and id_pc = 0 when EMPTY.
REQ-017 SHALL have zero-latency pass-through absent: a pushed instruction appears on id_* on the cycle after acceptance (1-cycle latency).
REQ-018 SHALL on clear=1 go to EMPTY at the next edge, discarding both entries and any simultaneous push; clear has priority over pause and push.
REQ-019 SHALL hold id_* stable while pause=1 and clear=0, with or without a simultaneous push into the skid slot.
REQ-020 SHALL ignore if_pc/if_inst when if_valid=0 and SHALL never drop or reorder an accepted instruction except on clear.
REQ-021 SHALL when in TWO with if_valid=1 and no pop, refuse the push (if_ready=0) and leave both entries unchanged.

Reset
REQ-022 SHALL on rst=0 asynchronously force state=EMPTY, both entries to pc=0/inst=NOP, id_valid=0, id_pc=0, id_inst=0x0800, if_ready=1.
REQ-023 SHALL on reset assertion mid-operation discard all entries; the first push after release is accepted normally.

Configuration
REQ-024 SHALL with IF_ID_PERF_CNT_EN defined add outputs flush_cnt[15:0] (edges with clear=1 and state!=EMPTY) and stall_cnt[15:0] (edges with pause=1, clear=0, id_valid=1), both saturating at 0xFFFF, reset to 0.
REQ-025 SHALL without IF_ID_PERF_CNT_EN omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-026 SHALL take NOP encoding, data widths (16), state encodings and CLEAR/PAUSE enable levels from the shared define package.
REQ-027 SHALL place the counters in one sub-module if_id_perf_cnt, instantiated only under IF_ID_PERF_CNT_EN.

Verification
REQ-028 SHALL cover: push pc=0x0010 inst=0x1234, no pause -> next cycle id_valid=1, id_pc=0x0010, id_inst=0x1234; next push 0x0011 -> id_pc=0x0011 one cycle later.
REQ-029 SHALL cover: pause=1 for 3 cycles with pushes 0x0020, 0x0021, 0x0022 -> id_pc held 0x0020, state TWO, if_ready=0 on cycle 3, 0x0022 not accepted.
REQ-030 SHALL cover: state TWO, pause released -> id_pc 0x0020 then 0x0021 on consecutive cycles, no loss.
REQ-031 SHALL cover: state TWO, clear=1, pause=1, if_valid=1 in the same cycle -> next cycle EMPTY, id_valid=0, id_inst=0x0800, flush_cnt +1 when enabled.
REQ-032 SHALL cover: rst=0 pulse asserted between clock edges while in ONE -> outputs return to reset values immediately, before the next edge.
REQ-033 SHALL cover: 70000 stalled cycles with IF_ID_PERF_CNT_EN -> stall_cnt=0xFFFF, no wrap.
